countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
//
// PURPOSE
// BCD countdown timer: the down-counting counterpart of the stopwatch counter.
// - Loads a preset time HH:MM:SS.cc and decrements it once per carry_i (0.01 s tick from the prescaler).
// - Asserts done_o when the count reaches 00:00:00.00.
// - Digit outputs use the same format as the stopwatch, so the top level muxes either one onto the 7-seg display.
//
// PARAMETERS
// AUTO_RELOAD  0  1: on expiry reload the stored preset and keep running; 0: stop in DONE
//
// PORTS
// clk       in   1   system clock
// rst       in   1   asynchronous reset, active-high
// carry_i   in   1   0.01 s tick, 1-cycle pulse
// load_i    in   1   capture preset_i into preset register and counter
// start_i   in   1   start/resume counting
// pause_i   in   1   pause counting
// preset_i  in   32  {HOUR1,HOUR0,MIN1,MIN0,SEG1,SEG0,CSEG1,CSEG0}, 4 bits BCD each
// CSEG0_o..HOUR1_o  out  4 each  current BCD digits (same order as preset_i)
// running_o out  1   high while state==RUN
// done_o    out  1   1-cycle pulse on expiry
//
// BEHAVIOUR
// - Reset (async, rst=1): all digits 0, preset register 0, state IDLE, running_o=0, done_o=0.
// - States: IDLE, RUN, PAUSE, DONE. All outputs are registered; no combinational input->output paths.
// - Input priority, every state: load_i > pause_i > start_i > carry_i.
// - load_i (any state):
//   - Clamp each digit: CSEG0/CSEG1/SEG0/MIN0/HOUR0/HOUR1 >9 -> 9; SEG1/MIN1 >5 -> 5.
//   - Write the clamped value to the preset register and the counter.
//   - Next state IDLE. Any pending done_o is not generated.
// - IDLE:
//   - start_i with counter != 0 -> RUN.
//   - start_i with counter == 0 -> stay IDLE, no done_o.
// - RUN:
//   - pause_i -> PAUSE; carry_i in that cycle is ignored.
//   - carry_i decrements the count with a borrow chain:
//     - b0=carry_i; b(n+1)=b(n) && digit(n)==0.
//     - A digit with b(n)=1 goes to digit-1, or wraps 0 -> max (9, or 5 for SEG1/MIN1).
//     - Example: 01:00:00.00 -> 00:59:59.99 on one tick.
// - Expiry: carry_i in RUN while counter == 00:00:00.01.
//   - Counter becomes 0; done_o=1 for exactly the next cycle.
//   - AUTO_RELOAD=0: state -> DONE, counter held at 0.
//   - AUTO_RELOAD=1: counter loads preset register instead of 0; state stays RUN.
//   - AUTO_RELOAD=1 with preset == 0: treated as AUTO_RELOAD=0.
// - PAUSE: digits frozen, carry_i ignored; start_i -> RUN.
// - DONE: digits held at 0; start_i ignored; only load_i (-> IDLE) leaves.
// - No borrow out of HOUR1: 00:00:00.00 is never decremented.
// - Latency: digits update in the cycle after the carry_i edge; running_o follows the state register.
//
// TESTING
// - Reset mid-RUN at 12:34:56.78 -> all digits 0, IDLE, running_o=0 immediately (async).
// - load 00:00:01.00, start, 100 carry_i ticks -> 00:00:00.00, exactly one done_o pulse, state DONE.
// - load 01:00:00.00, start, 1 tick -> 00:59:59.99 (full borrow chain).
// - preset_i with every digit = 4'hF -> counter 99:59:59.99 (clamped).
// - RUN, pause_i and carry_i same cycle -> count unchanged; PAUSE; ticks ignored; start_i resumes.
// - AUTO_RELOAD=1, preset 00:00:00.02, 4 ticks -> done_o pulses after ticks 2 and 4, counter back to 00:00:00.02, running_o stays 1.

Source files
------------

// File: rtl/countdown_timer.sv
// BCD countdown timer HH:MM:SS.cc, decremented once per 0.01 s carry tick.
// Digit outputs match the stopwatch format so the display mux can select either one.
//
// state | meaning
// IDLE  | preset loaded or reset, waiting for start
// RUN   | counting down on carry_i
// PAUSE | count frozen, start resumes
// DONE  | expired, held at zero until the next load
module countdown_timer #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        carry_i,
  input  logic        load_i,
  input  logic        start_i,
  input  logic        pause_i,
  input  logic [31:0] preset_i,
  output logic [3:0]  CSEG0_o,
  output logic [3:0]  CSEG1_o,
  output logic [3:0]  SEG0_o,
  output logic [3:0]  SEG1_o,
  output logic [3:0]  MIN0_o,
  output logic [3:0]  MIN1_o,
  output logic [3:0]  HOUR0_o,
  output logic [3:0]  HOUR1_o,
  output logic        running_o,
  output logic        done_o
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [31:0] preset, preset_nxt;
  logic [31:0] clamped, dec;
  logic        done, done_nxt;
  logic        borrow;

  // Tens-of-seconds and tens-of-minutes digits count 0..5, all others 0..9.
  function automatic logic [3:0] digit_max(input int n);
    return (n == 3 || n == 5) ? 4'd5 : 4'd9;
  endfunction

  always_comb begin
    clamped = '0;
    dec     = '0;
    borrow  = 1'b1;
    for (int n = 0; n < 8; n++) begin
      clamped[4*n +: 4] = (preset_i[4*n +: 4] > digit_max(n)) ? digit_max(n) : preset_i[4*n +: 4];
      if (borrow)
        dec[4*n +: 4] = (cnt[4*n +: 4] == 4'd0) ? digit_max(n) : cnt[4*n +: 4] - 4'd1;
      else
        dec[4*n +: 4] = cnt[4*n +: 4];
      borrow = borrow && (cnt[4*n +: 4] == 4'd0);
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    preset_nxt = preset;
    done_nxt   = 1'b0;
    if (load_i) begin
      preset_nxt = clamped;
      cnt_nxt    = clamped;
      state_nxt  = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!pause_i && start_i && cnt != '0) state_nxt = RUN;
        end
        RUN: begin
          if (pause_i) begin
            state_nxt = PAUSE;
          end else if (!start_i && carry_i && cnt != '0) begin
            // Expiry: next value would be zero.
            if (cnt == 32'h0000_0001) begin
              done_nxt = 1'b1;
              if (AUTO_RELOAD && preset != '0) begin
                cnt_nxt = preset;
              end else begin
                cnt_nxt   = '0;
                state_nxt = DONE;
              end
            end else begin
              cnt_nxt = dec;
            end
          end
        end
        PAUSE: begin
          if (!pause_i && start_i) state_nxt = RUN;
        end
        DONE: begin
          cnt_nxt = '0;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      preset <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      preset <= preset_nxt;
      done   <= done_nxt;
    end
  end

  assign CSEG0_o   = cnt[3:0];
  assign CSEG1_o   = cnt[7:4];
  assign SEG0_o    = cnt[11:8];
  assign SEG1_o    = cnt[15:12];
  assign MIN0_o    = cnt[19:16];
  assign MIN1_o    = cnt[23:20];
  assign HOUR0_o   = cnt[27:24];
  assign HOUR1_o   = cnt[31:28];
  assign running_o = (state == RUN);
  assign done_o    = done;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: one instance per AUTO_RELOAD setting, shared stimulus,
// checked every cycle against a centisecond-integer reference model.
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        carry_i, load_i, start_i, pause_i;
  logic [31:0] preset_i;

  logic [3:0] c0_a, c1_a, s0_a, s1_a, m0_a, m1_a, h0_a, h1_a;
  logic [3:0] c0_b, c1_b, s0_b, s1_b, m0_b, m1_b, h0_b, h1_b;
  logic       run_a, done_a, run_b, done_b;
  logic [31:0] dig [2];
  logic        run [2];
  logic        dn  [2];

  always #5 clk = ~clk;

  countdown_timer #(.AUTO_RELOAD(1'b0)) dut_a (
    .clk(clk), .rst(rst), .carry_i(carry_i), .load_i(load_i), .start_i(start_i),
    .pause_i(pause_i), .preset_i(preset_i),
    .CSEG0_o(c0_a), .CSEG1_o(c1_a), .SEG0_o(s0_a), .SEG1_o(s1_a),
    .MIN0_o(m0_a), .MIN1_o(m1_a), .HOUR0_o(h0_a), .HOUR1_o(h1_a),
    .running_o(run_a), .done_o(done_a));

  countdown_timer #(.AUTO_RELOAD(1'b1)) dut_b (
    .clk(clk), .rst(rst), .carry_i(carry_i), .load_i(load_i), .start_i(start_i),
    .pause_i(pause_i), .preset_i(preset_i),
    .CSEG0_o(c0_b), .CSEG1_o(c1_b), .SEG0_o(s0_b), .SEG1_o(s1_b),
    .MIN0_o(m0_b), .MIN1_o(m1_b), .HOUR0_o(h0_b), .HOUR1_o(h1_b),
    .running_o(run_b), .done_o(done_b));

  assign dig[0] = {h1_a, h0_a, m1_a, m0_a, s1_a, s0_a, c1_a, c0_a};
  assign dig[1] = {h1_b, h0_b, m1_b, m0_b, s1_b, s0_b, c1_b, c0_b};
  assign run[0] = run_a;
  assign run[1] = run_b;
  assign dn[0]  = done_a;
  assign dn[1]  = done_b;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: count held as total centiseconds.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_cnt [2];
  int m_pre [2];
  int m_st  [2];
  bit m_done[2];

  function automatic int to_cs(input logic [31:0] b);
    int h, m, s, c;
    h = int'(b[31:28]) * 10 + int'(b[27:24]);
    m = int'(b[23:20]) * 10 + int'(b[19:16]);
    s = int'(b[15:12]) * 10 + int'(b[11:8]);
    c = int'(b[7:4])   * 10 + int'(b[3:0]);
    return ((h * 60 + m) * 60 + s) * 100 + c;
  endfunction

  function automatic logic [31:0] to_bcd(input int v);
    int h, m, s, c;
    c = v % 100; v = v / 100;
    s = v % 60;  v = v / 60;
    m = v % 60;  h = v / 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic logic [31:0] clamp(input logic [31:0] p);
    logic [31:0] r;
    logic [3:0]  d, lim;
    r = p;
    for (int n = 0; n < 8; n++) begin
      d   = p[4*n +: 4];
      lim = (n == 3 || n == 5) ? 4'd5 : 4'd9;
      r[4*n +: 4] = (d > lim) ? lim : d;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_pre[k] = 0; m_st[k] = M_IDLE; m_done[k] = 1'b0;
    end
  endtask

  task automatic model_step(input bit ld, input bit ps, input bit st, input bit cy,
                            input logic [31:0] pre);
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 1'b0;
      if (ld) begin
        m_pre[k] = to_cs(clamp(pre));
        m_cnt[k] = m_pre[k];
        m_st[k]  = M_IDLE;
      end else if (m_st[k] == M_IDLE) begin
        if (!ps && st && m_cnt[k] != 0) m_st[k] = M_RUN;
      end else if (m_st[k] == M_RUN) begin
        if (ps) m_st[k] = M_PAUSE;
        else if (!st && cy && m_cnt[k] > 0) begin
          m_cnt[k] = m_cnt[k] - 1;
          if (m_cnt[k] == 0) begin
            m_done[k] = 1'b1;
            if (k == 1 && m_pre[k] != 0) m_cnt[k] = m_pre[k];
            else m_st[k] = M_DONE;
          end
        end
      end else if (m_st[k] == M_PAUSE) begin
        if (!ps && st) m_st[k] = M_RUN;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check(k == 0 ? "digits_ar0" : "digits_ar1", dig[k], to_bcd(m_cnt[k]));
      check(k == 0 ? "running_ar0" : "running_ar1", 32'(run[k]), 32'(m_st[k] == M_RUN));
      check(k == 0 ? "done_ar0" : "done_ar1", 32'(dn[k]), 32'(m_done[k]));
    end
  endtask

  task automatic step(input bit ld, input bit ps, input bit st, input bit cy,
                      input logic [31:0] pre);
    load_i = ld; pause_i = ps; start_i = st; carry_i = cy; preset_i = pre;
    @(posedge clk);
    #1;
    model_step(ld, ps, st, cy, pre);
    compare_all();
    load_i = 1'b0; pause_i = 1'b0; start_i = 1'b0; carry_i = 1'b0;
  endtask

  int pulses;
  int r;
  logic [31:0] p;

  initial begin
    rst = 1'b1; load_i = 1'b0; pause_i = 1'b0; start_i = 1'b0; carry_i = 1'b0;
    preset_i = '0;
    model_reset();
    #2;
    check("reset_digits", dig[0], 32'h0);
    check("reset_running", 32'(run[0]), 32'h0);
    check("reset_done", 32'(dn[0]), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full borrow chain
    step(1, 0, 0, 0, 32'h0100_0000);
    step(0, 0, 1, 0, '0);
    step(0, 0, 0, 1, '0);
    check("full_borrow", dig[0], 32'h0059_5999);

    // Clamp
    step(1, 0, 0, 0, 32'hFFFF_FFFF);
    check("clamp_all_f", dig[0], 32'h9959_5999);
    check("clamp_idle", 32'(run[0]), 32'h0);

    // Start with zero count does nothing
    step(1, 0, 0, 0, 32'h0);
    step(0, 0, 1, 0, '0);
    check("start_zero_idle", 32'(run[0]), 32'h0);

    // One second down to expiry
    step(1, 0, 0, 0, 32'h0000_0100);
    step(0, 0, 1, 0, '0);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0, 1, '0);
      if (dn[0]) pulses++;
    end
    check("expiry_digits", dig[0], 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, (i == 1), 1, '0);
      if (dn[0]) pulses++;
    end
    check("done_pulses", 32'(pulses), 32'd1);
    check("done_state_held", 32'(run[0]), 32'h0);
    check("done_digits_held", dig[0], 32'h0);

    // Pause and carry together, ticks ignored while paused, resume
    step(1, 0, 0, 0, 32'h0000_0050);
    step(0, 0, 1, 0, '0);
    step(0, 0, 0, 1, '0);
    step(0, 1, 0, 1, '0);
    check("pause_carry_same", dig[0], 32'h0000_0049);
    check("paused", 32'(run[0]), 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, '0);
    check("pause_frozen", dig[0], 32'h0000_0049);
    step(0, 0, 1, 0, '0);
    check("resumed", 32'(run[0]), 32'h1);
    step(0, 0, 0, 1, '0);
    check("resume_count", dig[0], 32'h0000_0048);

    // Auto reload on the second instance
    step(1, 0, 0, 0, 32'h0000_0002);
    step(0, 0, 1, 0, '0);
    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 1, '0);
    check("ar_done_tick2", 32'(dn[1]), 32'h1);
    check("ar_reload_tick2", dig[1], 32'h0000_0002);
    check("ar_running_tick2", 32'(run[1]), 32'h1);
    check("ar0_stopped", 32'(run[0]), 32'h0);
    step(0, 0, 0, 1, '0);
    check("ar_nodone_tick3", 32'(dn[1]), 32'h0);
    step(0, 0, 0, 1, '0);
    check("ar_done_tick4", 32'(dn[1]), 32'h1);
    check("ar_reload_tick4", dig[1], 32'h0000_0002);
    check("ar_running_tick4", 32'(run[1]), 32'h1);

    // Asynchronous reset mid-run
    step(1, 0, 0, 0, 32'h1234_5678);
    step(0, 0, 1, 0, '0);
    step(0, 0, 0, 1, '0);
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_digits", dig[0], 32'h0);
    check("async_rst_running", 32'(run[0]), 32'h0);
    check("async_rst_digits_ar1", dig[1], 32'h0);
    #1;
    rst = 1'b0;

    // Randomized traffic, one control input per cycle
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        case ($urandom_range(0, 3))
          0: p = $urandom();
          1: p = to_bcd($urandom_range(0, 40));
          2: p = to_bcd($urandom_range(90, 12000));
          default: p = to_bcd($urandom_range(0, 400));
        endcase
        step(1, 0, 0, 0, p);
      end else if (r < 4) step(0, 1, 0, 0, '0);
      else if (r < 12) step(0, 0, 1, 0, '0);
      else if (r < 80) step(0, 0, 0, 1, '0);
      else step(0, 0, 0, 0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
